// File: rtl/iob_mtimer_rsp.sv
// Purpose : single-hart machine timer (MSIP, MTIMECMP, MTIME) on the IOB native bus.
// Latency : reads return rdata with a one-cycle rvalid pulse the cycle after accept; writes land at the accept edge.
// Backpressure: none; ready is high every cycle out of reset, so every valid request is taken.
//
// Ports:
//   clk_i, rst_i                 system clock, synchronous active-high reset
//   iob_avalid_i/addr/wdata/wstrb request channel (wstrb == 0 means read)
//   iob_rvalid_o/rdata_o/ready_o  response channel
//   rtc_i                        asynchronous real-time tick input
//   mtip_o, msip_o               timer / software interrupt pending to the core
//
// Register map (byte address, bits [1:0] ignored):
//   0x00 MSIP (bit0)  0x08/0x0C MTIMECMP lo/hi  0x10/0x14 MTIME lo/hi
//   A read of 0x10 captures mtime[63:32] into a snapshot returned by 0x14,
//   so a lo-then-hi read pair is atomic even if a tick lands in between.

module iob_mtimer_rsp #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    input  logic                  rtc_i,
    output logic                  mtip_o,
    output logic                  msip_o
);

    localparam int STRB_W = DATA_W / 8;

    // Word selector taken from address bits [4:2].
    typedef enum logic [2:0] {
        SEL_MSIP    = 3'd0,
        SEL_RSVD1   = 3'd1,
        SEL_CMP_LO  = 3'd2,
        SEL_CMP_HI  = 3'd3,
        SEL_TIME_LO = 3'd4,
        SEL_TIME_HI = 3'd5,
        SEL_RSVD6   = 3'd6,
        SEL_RSVD7   = 3'd7
    } reg_sel_e;

    // Replace only the bytes whose strobe is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [63:0]       mtime_q;
    logic [63:0]       mtimecmp_q;
    logic [31:0]       snap_hi_q;
    logic              msip_q;
    logic              mtip_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rtc_s1_q;
    logic              rtc_s2_q;
    logic              rtc_s3_q;

    // Next-state values
    logic [63:0]       mtime_nxt;
    logic [63:0]       mtimecmp_nxt;
    logic              msip_nxt;
    logic [DATA_W-1:0] rd_mux;

    // Request decode
    reg_sel_e          sel;
    logic              req_acc;
    logic              req_wr;
    logic              req_rd;
    logic              tick;
    logic              mtime_wr;

    // Byte-lane bits of the address carry no information for word registers.
    logic              addr_lane_unused;
    assign addr_lane_unused = ^iob_addr_i[1:0];

    // Ready is simply "not in reset"; there is no internal stall source.
    assign iob_ready_o = ~rst_i;

    assign sel     = reg_sel_e'(iob_addr_i[4:2]);
    assign req_acc = iob_avalid_i & ~rst_i;
    assign req_wr  = req_acc & (|iob_wstrb_i);
    assign req_rd  = req_acc & ~(|iob_wstrb_i);

    // rtc_i is asynchronous: two flops resynchronise it, the third gives
    // the previous synchronised level for rising-edge detection.
    assign tick = rtc_s2_q & ~rtc_s3_q;

    assign mtime_wr = req_wr & ((sel == SEL_TIME_LO) | (sel == SEL_TIME_HI));

    // ------------------------------------------------------------------
    // Read mux: always samples the pre-edge register values.
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_MSIP:    rd_mux = {{(DATA_W-1){1'b0}}, msip_q};
            SEL_CMP_LO:  rd_mux = mtimecmp_q[31:0];
            SEL_CMP_HI:  rd_mux = mtimecmp_q[63:32];
            SEL_TIME_LO: rd_mux = mtime_q[31:0];
            SEL_TIME_HI: rd_mux = snap_hi_q;
            default:     rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register write / count logic
    // ------------------------------------------------------------------
    always_comb begin
        mtime_nxt    = mtime_q;
        mtimecmp_nxt = mtimecmp_q;
        msip_nxt     = msip_q;

        if (req_wr) begin
            case (sel)
                SEL_MSIP: begin
                    if (iob_wstrb_i[0]) begin
                        msip_nxt = iob_wdata_i[0];
                    end
                end
                SEL_CMP_LO: mtimecmp_nxt[31:0]  = merge_bytes(mtimecmp_q[31:0],  iob_wdata_i, iob_wstrb_i);
                SEL_CMP_HI: mtimecmp_nxt[63:32] = merge_bytes(mtimecmp_q[63:32], iob_wdata_i, iob_wstrb_i);
                default: ;
            endcase
        end

        // A bus write to either MTIME half owns all 64 bits for this cycle:
        // the untouched half holds rather than absorbing a coincident tick.
        if (mtime_wr) begin
            if (sel == SEL_TIME_LO) begin
                mtime_nxt[31:0]  = merge_bytes(mtime_q[31:0],  iob_wdata_i, iob_wstrb_i);
            end else begin
                mtime_nxt[63:32] = merge_bytes(mtime_q[63:32], iob_wdata_i, iob_wstrb_i);
            end
        end else if (tick) begin
            mtime_nxt = mtime_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            snap_hi_q  <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rtc_s1_q   <= 1'b0;
            rtc_s2_q   <= 1'b0;
            rtc_s3_q   <= 1'b0;
        end else begin
            rtc_s1_q   <= rtc_i;
            rtc_s2_q   <= rtc_s1_q;
            rtc_s3_q   <= rtc_s2_q;

            mtime_q    <= mtime_nxt;
            mtimecmp_q <= mtimecmp_nxt;
            msip_q     <= msip_nxt;

            // Compare uses the pre-edge values, so mtip trails changes by a cycle.
            mtip_q     <= (mtime_q >= mtimecmp_q);

            rvalid_q   <= req_rd;
            if (req_rd) begin
                rdata_q <= rd_mux;
                if (sel == SEL_TIME_LO) begin
                    snap_hi_q <= mtime_q[63:32];
                end
            end
        end
    end

    // A read accepted just before reset asserts must not surface its pulse.
    assign iob_rvalid_o = rvalid_q & ~rst_i;
    assign iob_rdata_o  = rdata_q;
    assign mtip_o       = mtip_q;
    assign msip_o       = msip_q;

endmodule
